// File: rtl/mgc_ace_snoop_initiator.sv
// ACE snoop initiator: issues one snoop on the AC channel, collects the CR response
// and forwards any CD line data, then reports a completion record.
module mgc_ace_snoop_initiator #(
   parameter int ADDR_WIDTH       = 64,
   parameter int SNOOP_DATA_WIDTH = 128,
   parameter int CACHE_LINE_SIZE  = 6
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_WIDTH-1:0]       req_addr,
   input  logic [3:0]                  req_snoop,
   input  logic [2:0]                  req_prot,
   output logic                        ACVALID,
   input  logic                        ACREADY,
   output logic [ADDR_WIDTH-1:0]       ACADDR,
   output logic [3:0]                  ACSNOOP,
   output logic [2:0]                  ACPROT,
   input  logic                        CRVALID,
   output logic                        CRREADY,
   input  logic [4:0]                  CRRESP,
   input  logic                        CDVALID,
   output logic                        CDREADY,
   input  logic [SNOOP_DATA_WIDTH-1:0] CDDATA,
   input  logic                        CDLAST,
   output logic                        dat_valid,
   input  logic                        dat_ready,
   output logic [SNOOP_DATA_WIDTH-1:0] dat_data,
   output logic                        dat_last,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [4:0]                  rsp_crresp,
   output logic                        rsp_err
);

   // state  | meaning
   // IDLE   | accepting a snoop command
   // AC     | snoop address presented, waiting for ACREADY
   // WAIT   | collecting CR response and CD line beats
   // RESP   | completion record presented, waiting for rsp_ready

   localparam int LINE_BYTES = 1 << CACHE_LINE_SIZE;
   localparam int BUS_BYTES  = SNOOP_DATA_WIDTH / 8;
   localparam int BEATS_RAW  = LINE_BYTES / BUS_BYTES;
   localparam int BEATS      = (BEATS_RAW < 1) ? 1 : BEATS_RAW;
   localparam int CNT_W      = $clog2(BEATS + 1);

   typedef enum logic [1:0] {S_IDLE, S_AC, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [4:0]         crresp_q;
   logic [CNT_W-1:0]   beat_cnt;
   logic               data_done;
   logic               err_q;

   logic               cd_elig;
   logic               cr_hs;
   logic               cd_hs;
   logic               cr_done;
   logic               resp0_now;
   logic               late_beat;
   logic               bad_last;
   logic [CNT_W-1:0]   count_nxt;
   logic               done_nxt;
   logic               wait_exit;

   assign req_ready  = (state == S_IDLE) && !ARESET;
   assign cd_elig    = (state == S_WAIT) && !data_done && !ARESET;
   assign CDREADY    = cd_elig && dat_ready;
   assign dat_valid  = cd_elig && CDVALID;
   assign dat_data   = cd_elig ? CDDATA : '0;
   assign dat_last   = cd_elig && CDLAST;
   assign rsp_crresp = crresp_q;
   assign rsp_err    = err_q;

   assign cr_hs     = CRVALID && CRREADY;
   assign cd_hs     = CDVALID && CDREADY;
   assign cr_done   = (state == S_WAIT) && !CRREADY;
   assign resp0_now = cr_hs ? CRRESP[0] : crresp_q[0];
   // a beat arriving after a no-data response was captured is a protocol error
   assign late_beat = cd_hs && cr_done && !crresp_q[0];
   assign bad_last  = cd_hs && (CDLAST != (beat_cnt == CNT_W'(BEATS - 1)));
   assign count_nxt = beat_cnt + CNT_W'(cd_hs);
   assign done_nxt  = data_done || late_beat || (cd_hs && (count_nxt == CNT_W'(BEATS)));
   assign wait_exit = (state == S_WAIT) && (cr_done || cr_hs) &&
                      (resp0_now ? done_nxt : ((count_nxt == '0) || done_nxt));

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= S_IDLE;
         ACVALID   <= 1'b0;
         ACADDR    <= '0;
         ACSNOOP   <= '0;
         ACPROT    <= '0;
         CRREADY   <= 1'b0;
         crresp_q  <= '0;
         beat_cnt  <= '0;
         data_done <= 1'b0;
         err_q     <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  ACADDR   <= req_addr;
                  ACSNOOP  <= req_snoop;
                  ACPROT   <= req_prot;
                  ACVALID  <= 1'b1;
                  beat_cnt <= '0;
                  state    <= S_AC;
               end
            end
            S_AC: begin
               if (ACREADY) begin
                  ACVALID   <= 1'b0;
                  CRREADY   <= 1'b1;
                  data_done <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               beat_cnt  <= count_nxt;
               data_done <= done_nxt;
               if (cr_hs) begin
                  crresp_q <= CRRESP;
                  CRREADY  <= 1'b0;
               end
               if (late_beat || bad_last)
                  err_q <= 1'b1;
               if (wait_exit) begin
                  CRREADY   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  err_q     <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mgc_ace_snoop_initiator.sv
// Bench for mgc_ace_snoop_initiator: directed snoop scenarios plus random snoops,
// checked against a line-level model of completion, error and latency rules.
module tb_mgc_ace_snoop_initiator;

   localparam int AW    = 64;
   localparam int DW    = 128;
   localparam int CLS   = 6;
   localparam int BEATS = (1 << CLS) / (DW / 8);

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_snoop;
   logic [2:0]    req_prot;
   logic          ACVALID, ACREADY;
   logic [AW-1:0] ACADDR;
   logic [3:0]    ACSNOOP;
   logic [2:0]    ACPROT;
   logic          CRVALID, CRREADY;
   logic [4:0]    CRRESP;
   logic          CDVALID, CDREADY;
   logic [DW-1:0] CDDATA;
   logic          CDLAST;
   logic          dat_valid, dat_ready;
   logic [DW-1:0] dat_data;
   logic          dat_last;
   logic          rsp_valid, rsp_ready;
   logic [4:0]    rsp_crresp;
   logic          rsp_err;

   mgc_ace_snoop_initiator #(.ADDR_WIDTH(AW), .SNOOP_DATA_WIDTH(DW), .CACHE_LINE_SIZE(CLS)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_snoop(req_snoop), .req_prot(req_prot),
      .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP), .ACPROT(ACPROT),
      .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
      .CDVALID(CDVALID), .CDREADY(CDREADY), .CDDATA(CDDATA), .CDLAST(CDLAST),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_crresp(rsp_crresp), .rsp_err(rsp_err)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // current snoop plan
   logic [AW-1:0] p_addr;
   logic [3:0]    p_snoop;
   logic [2:0]    p_prot;
   logic [4:0]    p_crresp;
   int            p_cr_after, p_nbeats, p_ac_dly, p_rsp_dly;
   bit            p_gaps, p_toggle;
   logic [DW-1:0] beat_data [8];
   logic          beat_last [8];

   task automatic set_plan(input logic [AW-1:0] addr, input logic [3:0] snoop, input logic [2:0] prot,
                           input logic [4:0] crresp, input int cr_after, input int nbeats,
                           input logic [7:0] last_mask, input int ac_dly, input int rsp_dly,
                           input bit gaps, input bit toggle);
      p_addr = addr; p_snoop = snoop; p_prot = prot; p_crresp = crresp;
      p_cr_after = cr_after; p_nbeats = nbeats; p_ac_dly = ac_dly; p_rsp_dly = rsp_dly;
      p_gaps = gaps; p_toggle = toggle;
      for (int i = 0; i < 8; i++) begin
         beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
         beat_last[i] = last_mask[i];
      end
   endtask

   // Error if any beat follows a no-data response, or any in-line beat has the wrong last flag.
   function automatic logic exp_err();
      logic e = 1'b0;
      if (!p_crresp[0] && p_cr_after > 0) e = 1'b1;
      for (int i = 0; i < p_nbeats; i++)
         if (i < BEATS && beat_last[i] != (i == BEATS - 1)) e = 1'b1;
      return e;
   endfunction

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_ctl"}, 128'({req_ready, ACVALID, CRREADY, CDREADY, dat_valid, dat_last,
                                     rsp_valid, rsp_err}), 128'(0));
      check_val({tag, "_acaddr"}, 128'(ACADDR), 128'(0));
      check_val({tag, "_fields"}, 128'({ACSNOOP, ACPROT, rsp_crresp}), 128'(0));
      check_val({tag, "_dat"}, 128'(dat_data), 128'(0));
   endtask

   task automatic do_req_ac();
      @(posedge ACLK); #1;
      req_valid = 1'b1; req_addr = p_addr; req_snoop = p_snoop; req_prot = p_prot;
      @(negedge ACLK);
      check_val("req_ready", 128'(req_ready), 128'(1));
      @(posedge ACLK); #1;
      req_valid = 1'b0; req_addr = ~p_addr; req_snoop = ~p_snoop; req_prot = ~p_prot;
      ACREADY = (p_ac_dly == 0);
      @(negedge ACLK);
      check_val("ac_lat", 128'(ACVALID), 128'(1));
      check_val("acaddr", 128'(ACADDR), 128'(p_addr));
      check_val("acsnoop_prot", 128'({ACSNOOP, ACPROT}), 128'({p_snoop, p_prot}));
      for (int i = 1; i <= p_ac_dly; i++) begin
         @(posedge ACLK); #1;
         ACREADY = (i == p_ac_dly);
         @(negedge ACLK);
         check_val("ac_hold", 128'(ACVALID), 128'(1));
         check_val("acaddr_hold", 128'(ACADDR), 128'(p_addr));
      end
      @(posedge ACLK); #1;
      ACREADY = 1'b0;
   endtask

   task automatic pulse_reset();
      ARESET = 1'b1; CDVALID = 1'b0; CRVALID = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   task automatic run_txn();
      int  cd_done = 0, cr_cyc = -1, cd_cyc = -1, seen_cyc = 0, exp_lat;
      bit  cr_done = 0, seen = 0, cd_hs, cr_hs;
      do_req_ac();
      for (int t = 0; t < 200; t++) begin
         CRVALID = !cr_done && (cd_done >= p_cr_after);
         CRRESP  = p_crresp;
         if (!CDVALID && cd_done < p_nbeats && (p_crresp[0] || cd_done < p_cr_after || cr_done))
            CDVALID = p_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         CDDATA    = beat_data[cd_done];
         CDLAST    = beat_last[cd_done];
         dat_ready = p_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge ACLK);
         if (rsp_valid) begin
            seen = 1; seen_cyc = cyc;
            break;
         end
         check_val("ac_drop", 128'(ACVALID), 128'(0));
         check_val("crready", 128'(CRREADY), 128'(!cr_done));
         check_val("cdready", 128'(CDREADY), 128'(dat_ready && cd_done < BEATS));
         check_val("dat_valid", 128'(dat_valid), 128'(CDVALID));
         cd_hs = CDVALID && CDREADY;
         cr_hs = CRVALID && CRREADY;
         if (cd_hs) begin
            check_val("dat_data", 128'(dat_data), 128'(beat_data[cd_done]));
            check_val("dat_last", 128'(dat_last), 128'(beat_last[cd_done]));
            cd_done++;
            cd_cyc = cyc;
         end
         if (cr_hs) cr_cyc = cyc;
         @(posedge ACLK); #1;
         if (cr_hs) cr_done = 1;
         if (cd_hs) CDVALID = 1'b0;
      end
      CDVALID = 1'b0; CRVALID = 1'b0;
      check_val("rsp_seen", 128'(seen), 128'(1));
      if (!seen) begin
         pulse_reset();
         return;
      end
      exp_lat = ((cr_cyc > cd_cyc) ? cr_cyc : cd_cyc) + 1;
      check_val("rsp_lat", 128'(seen_cyc), 128'(exp_lat));
      check_val("n_beats", 128'(cd_done), 128'(p_nbeats));
      for (int i = 0; i <= p_rsp_dly; i++) begin
         if (i > 0) @(negedge ACLK);
         check_val("rsp_valid", 128'(rsp_valid), 128'(1));
         check_val("rsp_crresp", 128'(rsp_crresp), 128'(p_crresp));
         check_val("rsp_err", 128'(rsp_err), 128'(exp_err()));
         check_val("rsp_req_ready", 128'(req_ready), 128'(0));
      end
      @(posedge ACLK); #1;
      rsp_ready = 1'b1;
      @(negedge ACLK);
      check_val("rsp_hs_valid", 128'(rsp_valid), 128'(1));
      @(posedge ACLK); #1;
      rsp_ready = 1'b0;
      @(negedge ACLK);
      check_val("rsp_drop", 128'(rsp_valid), 128'(0));
      check_val("idle_ready", 128'(req_ready), 128'(1));
   endtask

   task automatic reset_mid();
      set_plan({$urandom, $urandom}, 4'h3, 3'h1, 5'h01, 4, 4, 8'h08, 0, 0, 0, 0);
      do_req_ac();
      CDVALID = 1'b1; CDDATA = beat_data[0]; CDLAST = 1'b0; dat_ready = 1'b1;
      @(negedge ACLK);
      check_val("pre_rst_cdready", 128'(CDREADY), 128'(1));
      @(posedge ACLK); #1;
      CDDATA = beat_data[1]; CRVALID = 1'b1; CRRESP = 5'h1F;
      ARESET = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      check_reset_outs("rst_mid");
      @(posedge ACLK); #1;
      ARESET = 1'b0; CDVALID = 1'b0; CRVALID = 1'b0;
      @(negedge ACLK);
      check_val("rst_idle", 128'(req_ready), 128'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0] cr_r;
      int         k, nb;
      logic [7:0] lm;
      ARESET = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_snoop = '0; req_prot = '0;
      ACREADY = 1'b0; CRVALID = 1'b0; CRRESP = '0;
      CDVALID = 1'b0; CDDATA = '0; CDLAST = 1'b0; dat_ready = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_reset_outs("por");
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      check_val("por_idle", 128'(req_ready), 128'(1));

      // no-data snoop, slow ACREADY
      set_plan(64'h1000, 4'h1, 3'h0, 5'h00, 0, 0, 8'h00, 3, 0, 0, 0);
      run_txn();
      // CR first, full line, dat_ready toggling
      set_plan({$urandom, $urandom}, 4'h7, 3'h2, 5'h01, 0, 4, 8'h08, 1, 0, 0, 1);
      run_txn();
      // two beats before CR, CR together with beat 2
      set_plan({$urandom, $urandom}, 4'h2, 3'h5, 5'h01, 2, 4, 8'h08, 0, 0, 0, 0);
      run_txn();
      // CDLAST early on beat 1
      set_plan({$urandom, $urandom}, 4'h1, 3'h0, 5'h01, 4, 4, 8'h0A, 0, 0, 0, 0);
      run_txn();
      // beat after a no-data response
      set_plan({$urandom, $urandom}, 4'h1, 3'h0, 5'h00, 1, 2, 8'h00, 0, 0, 0, 0);
      run_txn();
      // slow rsp_ready
      set_plan({$urandom, $urandom}, 4'hB, 3'h7, 5'h09, 1, 4, 8'h08, 2, 5, 1, 1);
      run_txn();

      reset_mid();
      set_plan({$urandom, $urandom}, 4'h1, 3'h0, 5'h01, 0, 4, 8'h08, 0, 0, 0, 0);
      run_txn();

      for (int n = 0; n < 40; n++) begin
         cr_r = 5'($urandom);
         if (cr_r[0]) begin
            k  = $urandom_range(0, 4);
            nb = BEATS;
            lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h08;
         end else begin
            k  = $urandom_range(0, 3);
            nb = (k == 0) ? 0 : k + 1;
            lm = 8'($urandom);
         end
         set_plan({$urandom, $urandom}, 4'($urandom), 3'($urandom), cr_r, k, nb, lm,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         run_txn();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mgc_ace_snoop_initiator.md
MGC_ACE_SNOOP_INITIATOR -- requirements
Module: mgc_ace_snoop_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, ACADDR and req_addr width.
REQ-002 SHALL have parameter SNOOP_DATA_WIDTH, default 128, CDDATA width in bits; legal values are 32, 64, 128, 256 and 512.
REQ-003 SHALL have parameter CACHE_LINE_SIZE, default 6, log2 of line bytes; beats per line BEATS = 2^CACHE_LINE_SIZE / (SNOOP_DATA_WIDTH/8), minimum 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports listed in order below.
REQ-005 ACLK  in  1  clock; all state updates on the rising edge.
REQ-006 ARESET  in  1  synchronous active-high reset.
REQ-007 req_valid/req_ready  in/out  1/1  snoop command handshake.
REQ-008 req_addr/req_snoop/req_prot  in  ADDR_WIDTH/4/3  snoop command fields.
REQ-009 ACVALID/ACREADY  out/in  1/1  snoop address channel handshake.
REQ-010 ACADDR/ACSNOOP/ACPROT  out  ADDR_WIDTH/4/3  snoop address channel payload.
REQ-011 CRVALID/CRREADY  in/out  1/1; CRRESP  in  5  snoop response channel.
REQ-012 CDVALID/CDREADY  in/out  1/1; CDDATA  in  SNOOP_DATA_WIDTH; CDLAST  in  1  snoop data channel.
REQ-013 dat_valid/dat_ready  out/in  1/1; dat_data  out  SNOOP_DATA_WIDTH; dat_last  out  1  forwarded line data.
REQ-014 rsp_valid/rsp_ready  out/in  1/1; rsp_crresp  out  5; rsp_err  out  1  completion record.

Function
REQ-015 SHALL keep one snoop outstanding; states IDLE, AC, WAIT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid&req_ready, capture the fields and go to AC; ACVALID=1 in the next cycle.
REQ-017 AC: ACVALID=1; ACADDR, ACSNOOP and ACPROT SHALL stay stable until ACVALID&ACREADY; that cycle -> WAIT.
REQ-018 WAIT: CRREADY=1 until the CR handshake; captured CRRESP held in a register.
REQ-019 WAIT: CDREADY = dat_ready while data beats are pending, so CD beats are accepted before, with, or after CR.
REQ-020 dat_valid=CDVALID, dat_data=CDDATA and dat_last=CDLAST SHALL pass through combinationally while CDREADY is eligible; dat_valid=0 otherwise.
REQ-021 Beat counter: 0..BEATS, increments on each CD handshake, cleared on entering AC; data is complete when count == BEATS.
REQ-022 Exit WAIT when CR is done and either (captured CRRESP[0]==0 and count==0) or (CRRESP[0]==1 and count==BEATS); -> RESP.
REQ-023 Any CD beat with CRRESP[0]==0 already captured SHALL set err and end data acceptance; exit follows REQ-022 treating data as done.
REQ-024 CDLAST=1 on beat index < BEATS-1, or CDLAST=0 on beat BEATS-1, SHALL set err; the counter still advances; beats beyond BEATS are not accepted.
REQ-025 CR and final CD handshakes in the same cycle SHALL be accepted together, with rsp_valid in the next cycle.
REQ-026 RESP: rsp_valid=1, rsp_crresp=captured CRRESP, rsp_err=err, all held stable until rsp_ready; then -> IDLE and err cleared.
REQ-027 Minimum latency: req handshake N -> ACVALID N+1; CR handshake M with no data -> rsp_valid M+1.

Reset
REQ-028 While ARESET=1: state IDLE; ACVALID, CRREADY, CDREADY, dat_valid and rsp_valid are 0; req_ready=0; payload outputs, counter and err are 0.
REQ-029 Reset asserted mid-snoop SHALL abandon the transaction; the first cycle after deassertion is IDLE with req_ready=1.

Verification
REQ-030 Bench SHALL cover, with BEATS=4: addr 0x1000, snoop 0x1; ACREADY after 3 cycles; CRRESP=0x00 -> ACADDR held for 3 cycles; rsp_crresp=0x00, rsp_err=0.
REQ-031 Bench SHALL cover: CRRESP=0x01, then 4 CD beats with CDLAST on beat 3 and dat_ready toggling -> 4 dat beats in order, rsp_err=0.
REQ-032 Bench SHALL cover: 2 CD beats before CR, CR=0x01 together with beat 2, beat 3 last -> rsp_valid one cycle after the beat-3 handshake, rsp_err=0.
REQ-033 Bench SHALL cover: CDLAST on beat 1 -> rsp_err=1; a CD beat after CRRESP=0x00 -> rsp_err=1.
REQ-034 Bench SHALL cover: ARESET pulsed during WAIT -> all outputs 0 during reset; the next request completes normally.
REQ-035 Bench SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid and rsp fields stable and req_ready=0 throughout.
